// File: rtl/div_issue_ctrl_if.sv
// Operand and result handshake bundle for div_issue_ctrl.
// master drives operands and consumes results; slave is the controller.
interface div_issue_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_q;
  logic [4:0] out_r;
  logic       out_dz;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_dz
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_q, out_r, out_dz
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/collect stage around a combinational 4-bit divider.
// Queues operand pairs, holds them on the divider, captures Q/R.
module div_issue_ctrl #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  div_issue_ctrl_if.slave  bus,
  output logic [3:0]       div_x,
  output logic [3:0]       div_y,
  input  logic [3:0]       div_q,
  input  logic [4:0]       div_r,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, SETTLE, DONE
  } state_t;

  state_t        state;
  logic [3:0]    mem_x [DEPTH];
  logic [3:0]    mem_y [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] cnt;
  logic          out_valid;
  logic [3:0]    out_q;
  logic [4:0]    out_r;
  logic          out_dz;
  logic          push;
  logic          pop;
  logic [3:0]    head_x;
  logic [3:0]    head_y;

  // No pass-through when full: ready looks only at the registered count.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = out_valid;
  assign bus.out_q     = out_q;
  assign bus.out_r     = out_r;
  assign bus.out_dz    = out_dz;

  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = (state == IDLE) && (count != '0);
  assign head_x = mem_x[rd_ptr];
  assign head_y = mem_y[rd_ptr];
  assign busy   = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= bus.in_x;
      mem_y[wr_ptr] <= bus.in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dz    <= 1'b0;
      div_x     <= '0;
      div_y     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      unique case (state)
        IDLE: begin
          if (count != '0) begin
            if (head_y == 4'd0) begin
              // Trapped locally; the divider never sees a zero divisor.
              out_q     <= 4'hF;
              out_r     <= {1'b0, head_x};
              out_dz    <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              div_x <= head_x;
              div_y <= head_y;
              cnt   <= SW'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            out_q     <= div_q;
            out_r     <= div_r;
            out_dz    <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - SW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider.
// Vector table for single ops, hand sequences for queueing corners.
module tb_div_issue_ctrl;
  logic       clk;
  logic       rst;
  logic [3:0] div_x;
  logic [3:0] div_y;
  logic [3:0] div_q;
  logic [4:0] div_r;
  logic       busy;

  int tests;
  int fails;

  div_issue_ctrl_if bus ();

  div_issue_ctrl #(
    .DEPTH        (4),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .div_x(div_x),
    .div_y(div_y),
    .div_q(div_q),
    .div_r(div_r),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    div_q = 4'd0;
    div_r = 5'd0;
    if (div_y != 4'd0) begin
      div_q = div_x / div_y;
      div_r = {1'b0, div_x % div_y};
    end
  end

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] q;
    logic [4:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_one(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    chk("push_ready", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  vec_t       vt [8];
  logic [3:0] bx [6];
  logic [3:0] by [6];
  logic [3:0] bq [6];
  logic [4:0] br [6];
  logic       bd [6];

  initial begin
    int         n;
    int         acc;
    int         got;
    int         stable;
    logic       go;
    logic [3:0] px;
    logic [3:0] py;

    tests = 0;
    fails = 0;
    vt[0] = '{4'd6,  4'd2,  4'd3,  5'd0, 1'b0, 3};
    vt[1] = '{4'd12, 4'd3,  4'd4,  5'd0, 1'b0, 3};
    vt[2] = '{4'd13, 4'd12, 4'd1,  5'd1, 1'b0, 3};
    vt[3] = '{4'd5,  4'd10, 4'd0,  5'd5, 1'b0, 3};
    vt[4] = '{4'd9,  4'd0,  4'hF,  5'h09, 1'b1, 1};
    vt[5] = '{4'd15, 4'd1,  4'd15, 5'd0, 1'b0, 3};
    vt[6] = '{4'd0,  4'd7,  4'd0,  5'd0, 1'b0, 3};
    vt[7] = '{4'd0,  4'd0,  4'hF,  5'd0, 1'b1, 1};
    bx = '{4'd6, 4'd9, 4'd14, 4'd8, 4'd3, 4'd15};
    by = '{4'd2, 4'd0, 4'd3,  4'd8, 4'd5, 4'd4};
    bq = '{4'd3, 4'hF, 4'd4,  4'd1, 4'd0, 4'd3};
    br = '{5'd0, 5'd9, 5'd2,  5'd0, 5'd3, 5'd3};
    bd = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_x      = 4'd0;
    bus.in_y      = 4'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_q", int'(bus.out_q), 0);
    chk("rst_out_r", int'(bus.out_r), 0);
    chk("rst_out_dz", int'(bus.out_dz), 0);
    chk("rst_div_x", int'(div_x), 0);
    chk("rst_div_y", int'(div_y), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      px = div_x;
      py = div_y;
      push_one(vt[i].x, vt[i].y);
      wait_valid(n);
      chk($sformatf("v%0d_latency", i), n, vt[i].lat);
      chk($sformatf("v%0d_q", i), int'(bus.out_q), int'(vt[i].q));
      chk($sformatf("v%0d_r", i), int'(bus.out_r), int'(vt[i].r));
      chk($sformatf("v%0d_dz", i), int'(bus.out_dz), int'(vt[i].dz));
      if (vt[i].dz) begin
        chk($sformatf("v%0d_div_x_held", i), int'(div_x), int'(px));
        chk($sformatf("v%0d_div_y_held", i), int'(div_y), int'(py));
      end
      take_result();
      chk($sformatf("v%0d_valid_drop", i), int'(bus.out_valid), 0);
    end

    // Fill with the consumer stalled, then drain in order.
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.in_valid = (acc < 6);
      if (acc < 6) begin
        bus.in_x = bx[acc];
        bus.in_y = by[acc];
      end
      go = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (go) acc++;
    end
    @(negedge clk);
    chk("b2b_accepted", acc, 5);
    chk("b2b_full_ready", int'(bus.in_ready), 0);
    chk("b2b_busy", int'(busy), 1);
    got = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && got < 6; c++) begin
      bus.in_valid = (acc < 6);
      if (acc < 6) begin
        bus.in_x = bx[acc];
        bus.in_y = by[acc];
      end
      go = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        chk($sformatf("b2b%0d_q", got), int'(bus.out_q), int'(bq[got]));
        chk($sformatf("b2b%0d_r", got), int'(bus.out_r), int'(br[got]));
        chk($sformatf("b2b%0d_dz", got), int'(bus.out_dz), int'(bd[got]));
        got++;
      end
      @(posedge clk);
      if (go) acc++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("b2b_results", got, 6);
    chk("b2b_sixth_accepted", acc, 6);
    repeat (2) @(negedge clk);
    chk("b2b_idle", int'(busy), 0);

    // Stall in DONE with another pair queued behind it.
    push_one(4'd11, 4'd2);
    wait_valid(n);
    chk("bp_latency", n, 3);
    push_one(4'd4, 4'd1);
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_q != 4'd5 ||
          bus.out_r != 5'd1 || bus.out_dz != 1'b0)
        stable = 0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_no_pop_x", int'(div_x), 11);
    chk("bp_no_pop_y", int'(div_y), 2);
    take_result();
    wait_valid(n);
    chk("bp_second_latency", n, 3);
    chk("bp_second_q", int'(bus.out_q), 4);
    chk("bp_second_r", int'(bus.out_r), 0);
    take_result();

    // Reset while SETTLE is active and two pairs are queued.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x = 4'd10;
    bus.in_y = 4'd3;
    @(negedge clk);
    bus.in_x = 4'd7;
    bus.in_y = 4'd2;
    @(negedge clk);
    bus.in_x = 4'd8;
    bus.in_y = 4'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_busy_before", int'(busy), 1);
    chk("mid_div_x", int'(div_x), 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("mid_busy_after", int'(busy), 0);
    chk("mid_in_ready", int'(bus.in_ready), 1);
    chk("mid_div_x_rst", int'(div_x), 0);
    stable = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid || busy) stable = 1;
    end
    chk("mid_no_result", stable, 0);
    bus.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
